// File: rtl/ledm_scan_driver.sv
// ledm_scan_driver: column-multiplexed 5x8 LED matrix refresh with shadow/active frames.
// Optional BRIGHTNESS_EN adds bright[3:0], a per-frame row duty control.
module ledm_scan_driver #(
  parameter int N_COLS         = 5,
  parameter int N_ROWS         = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 500,
  parameter bit COL_ACTIVE_LOW = 1'b1
) (
  input  logic              CLOCK_50MHz,
  input  logic              RESET_N,
  input  logic              wr_en,
  input  logic [2:0]        wr_col,
  input  logic [N_ROWS-1:0] wr_data,
  input  logic              swap_req,
`ifdef BRIGHTNESS_EN
  input  logic [3:0]        bright,
`endif
  output logic              swap_pending,
  output logic              swap_done,
  output logic              frame_tick,
  output logic [N_COLS-1:0] LEDM_C,
  output logic [N_ROWS-1:0] LEDM_R
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] BLANK_L    = DW'(BLANK_CYC);
  localparam logic [CW-1:0] COL_LAST   = CW'(N_COLS - 1);
  localparam logic [N_COLS-1:0] COL_OFF =
    COL_ACTIVE_LOW ? {N_COLS{1'b1}} : {N_COLS{1'b0}};

  logic [DW-1:0]     dwell_cnt;
  logic [CW-1:0]     col_idx;
  logic [N_ROWS-1:0] shadow [N_COLS];
  logic [N_ROWS-1:0] active [N_COLS];

  logic              dwell_end;
  logic              frame_end;
  logic              do_swap;
  logic              frame_start;
  logic              wr_ok;
  logic              drive;
  logic              row_en;
  logic [N_COLS-1:0] col_drv;

  assign dwell_end   = (dwell_cnt == DWELL_LAST);
  assign frame_end   = dwell_end && (col_idx == COL_LAST);
  assign do_swap     = frame_end && (swap_pending || swap_req);
  assign frame_start = (col_idx == '0) && (dwell_cnt == '0);
  assign wr_ok       = wr_en && ({1'b0, wr_col} < 4'(N_COLS));

`ifdef BRIGHTNESS_EN
  localparam int DRIVE_CYC = SCAN_DIV - BLANK_CYC;
  logic [3:0]    bright_q;
  logic [DW-1:0] drive_off;
  logic [31:0]   on_lim;
`endif

  always_comb begin
    col_drv = COL_OFF ^ (N_COLS'(1) << col_idx);
    drive   = (dwell_cnt >= BLANK_L);
`ifdef BRIGHTNESS_EN
    drive_off = dwell_cnt - BLANK_L;
    on_lim    = ((32'(bright_q) + 32'd1) * 32'(DRIVE_CYC)) >> 4;
    row_en    = drive && (32'(drive_off) < on_lim);
`else
    row_en    = drive;
`endif
  end

  always_ff @(posedge CLOCK_50MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      dwell_cnt    <= '0;
      col_idx      <= '0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
      frame_tick   <= 1'b0;
      LEDM_C       <= COL_OFF;
      LEDM_R       <= '0;
      for (int i = 0; i < N_COLS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
`ifdef BRIGHTNESS_EN
      bright_q     <= 4'hF;
`endif
    end else begin
      dwell_cnt <= dwell_end ? '0 : dwell_cnt + 1'b1;
      if (dwell_end)
        col_idx <= (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
      if (wr_ok)
        shadow[wr_col] <= wr_data;
      // copy uses the pre-write shadow when a write coincides
      if (do_swap)
        active <= shadow;
      swap_pending <= do_swap ? 1'b0 : (swap_pending | swap_req);
      swap_done    <= do_swap;
      frame_tick   <= frame_start;
      LEDM_C       <= drive ? col_drv : COL_OFF;
      LEDM_R       <= row_en ? active[col_idx] : '0;
`ifdef BRIGHTNESS_EN
      if (frame_start)
        bright_q <= bright;
`endif
    end
  end

endmodule

// File: tb/tb_ledm_scan_driver.sv
// tb_ledm_scan_driver: directed frame-by-frame checks of ledm_scan_driver.
// Runs with SCAN_DIV=8, BLANK_CYC=2; brightness frames only under BRIGHTNESS_EN.
module tb_ledm_scan_driver;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FR = 5 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_col = '0;
  logic [7:0] wr_data = '0;
  logic       swap_req = 1'b0;
  logic       swap_pending;
  logic       swap_done;
  logic       frame_tick;
  logic [4:0] ledm_c;
  logic [7:0] ledm_r;
`ifdef BRIGHTNESS_EN
  logic [3:0] bright = 4'hF;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int exp_bright = 15;

  logic [7:0] exp_act [5];
  logic       st_wr [FR];
  logic [2:0] st_col [FR];
  logic [7:0] st_dat [FR];
  logic       st_sw [FR];

  always #5 clk = ~clk;

  ledm_scan_driver #(
    .N_COLS(5), .N_ROWS(8), .SCAN_DIV(SD),
    .BLANK_CYC(BC), .COL_ACTIVE_LOW(1'b1)
  ) dut (
    .CLOCK_50MHz (clk),
    .RESET_N     (rst_n),
    .wr_en       (wr_en),
    .wr_col      (wr_col),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
`ifdef BRIGHTNESS_EN
    .bright      (bright),
`endif
    .swap_pending(swap_pending),
    .swap_done   (swap_done),
    .frame_tick  (frame_tick),
    .LEDM_C      (ledm_c),
    .LEDM_R      (ledm_r)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stim();
    for (int i = 0; i < FR; i++) begin
      st_wr[i]  = 1'b0;
      st_col[i] = '0;
      st_dat[i] = '0;
      st_sw[i]  = 1'b0;
    end
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (!frame_tick && n < 60) begin
      step();
      n++;
    end
    check(tag, 32'(frame_tick), 32'd1);
  endtask

  // Called on the sample where frame_tick is high (column 0, first blank cycle).
  task automatic run_frame(input string tag, input int ncyc);
    logic       pend;
    logic       did;
    int         c;
    int         d;
    int         lim;
    logic       drv;
    logic [4:0] ec;
    logic [7:0] er;
    logic [15:0] e;
    pend = 1'b0;
    did  = 1'b0;
    lim  = ((exp_bright + 1) * (SD - BC)) / 16;
    for (int i = 0; i < ncyc; i++) begin
      c   = i / SD;
      d   = i % SD;
      drv = (d >= BC);
      ec  = drv ? ~(5'b00001 << c) : 5'b11111;
      er  = (drv && (d - BC) < lim) ? exp_act[c] : 8'h00;
      e   = {5'b0, pend, (i == 0), (i == FR - 1) && did, ec, er};
      check($sformatf("%s[%0d]", tag, i),
            32'({5'b0, swap_pending, frame_tick, swap_done, ledm_c, ledm_r}),
            32'(e));
      wr_en    = st_wr[i];
      wr_col   = st_col[i];
      wr_data  = st_dat[i];
      swap_req = st_sw[i];
      if (i == FR - 2) begin
        did  = pend || st_sw[i];
        pend = 1'b0;
      end else if (st_sw[i]) begin
        pend = 1'b1;
      end
      step();
    end
    wr_en    = 1'b0;
    swap_req = 1'b0;
    clr_stim();
  endtask

  initial begin
    clr_stim();
    for (int i = 0; i < 5; i++) exp_act[i] = 8'h00;

    repeat (3) step();
    check("reset", 32'({swap_pending, frame_tick, swap_done, ledm_c, ledm_r}),
          32'({3'b000, 5'b11111, 8'h00}));
    rst_n = 1'b1;
    wait_tick("sync0");

    // blank frame; load col0/col4 and request a swap
    st_wr[3] = 1'b1; st_col[3] = 3'd0; st_dat[3] = 8'hA5;
    st_wr[4] = 1'b1; st_col[4] = 3'd4; st_dat[4] = 8'h3C;
    st_sw[10] = 1'b1;
    run_frame("f1", FR);

    // write coincident with the boundary swap
    exp_act = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h3C};
    st_wr[FR-2] = 1'b1; st_col[FR-2] = 3'd0; st_dat[FR-2] = 8'hFF;
    st_sw[FR-2] = 1'b1;
    run_frame("f2", FR);

    // out-of-range column write, double swap request
    st_wr[5] = 1'b1; st_col[5] = 3'd5; st_dat[5] = 8'hFF;
    st_sw[10] = 1'b1;
    st_sw[20] = 1'b1;
    run_frame("f3", FR);

    // pending swap, then reset mid-DRIVE of column 0
    exp_act = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h3C};
    st_wr[0] = 1'b1; st_col[0] = 3'd2; st_dat[0] = 8'h81;
    st_sw[1] = 1'b1;
    run_frame("f4", 5);
    check("pre_rst", 32'({swap_pending, ledm_c, ledm_r}),
          32'({1'b1, 5'b11110, 8'hFF}));
    #1 rst_n = 1'b0;
    #1 check("async_rst",
             32'({swap_pending, swap_done, frame_tick, ledm_c, ledm_r}),
             32'({3'b000, 5'b11111, 8'h00}));
    step();
    step();
    check("rst_hold", 32'({swap_pending, ledm_c, ledm_r}),
          32'({1'b0, 5'b11111, 8'h00}));
    rst_n = 1'b1;
    wait_tick("sync1");

    // buffers cleared, nothing pending; then a fresh swap
    for (int i = 0; i < 5; i++) exp_act[i] = 8'h00;
    st_wr[2] = 1'b1; st_col[2] = 3'd3; st_dat[2] = 8'h5A;
    st_sw[3] = 1'b1;
    run_frame("f5", FR);

    exp_act = '{8'h00, 8'h00, 8'h00, 8'h5A, 8'h00};
`ifdef BRIGHTNESS_EN
    bright = 4'd7;
`endif
    run_frame("f6", FR);
`ifdef BRIGHTNESS_EN
    exp_bright = 7;
    run_frame("f7", FR);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
